// File: rtl/memory_stage_pkg.sv
`default_nettype none
//==============================================================================
// Package     : memory_stage_pkg
// Description : Shared types for the M stage: data-bus request/response,
//               access size and strobe types, pipeline register payloads
//               and the op encoding, plus small op-classification helpers.
// Revision    : 1.0 - initial release
//==============================================================================
package memory_stage_pkg;

   typedef logic [63:0] word_t;
   typedef logic [63:0] addr_t;
   typedef logic [4:0]  creg_addr_t;
   typedef logic [7:0]  strobe_t;

   // Bus access size, one encoding per power-of-two byte count
   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic    valid;
      addr_t   addr;
      msize_t  size;
      strobe_t strobe;
      word_t   data;
   } dbus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } dbus_resp_t;

   // Decoded operation; only the memory ops matter to this stage
   typedef enum logic [4:0] {
      NOP = 5'd0,
      ADD = 5'd1,
      SUB = 5'd2,
      SLL = 5'd3,
      LUI = 5'd4,
      JAL = 5'd5,
      LB  = 5'd6,
      LH  = 5'd7,
      LW  = 5'd8,
      LD  = 5'd9,
      LBU = 5'd10,
      LHU = 5'd11,
      LWU = 5'd12,
      SB  = 5'd13,
      SH  = 5'd14,
      SW  = 5'd15,
      SD  = 5'd16
   } op_t;

   typedef struct packed {
      op_t  op;
      logic regWrite;
   } control_t;

   typedef struct packed {
      addr_t      pc;
      control_t   ctl;
      creg_addr_t dst;
      word_t      result;
      addr_t      memory_address;
      logic       is_bubble;
   } execute_data_t;

   typedef struct packed {
      addr_t      pc;
      control_t   ctl;
      creg_addr_t dst;
      word_t      result;
      logic       is_bubble;
   } memory_data_t;

   function automatic logic isStore(input op_t op);
      return (op == SB) || (op == SH) || (op == SW) || (op == SD);
   endfunction

   function automatic logic isMemOp(input op_t op);
      return isStore(op) || (op == LB) || (op == LH) || (op == LW) ||
             (op == LD) || (op == LBU) || (op == LHU) || (op == LWU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/memory_stage_if.sv
`default_nettype none
//==============================================================================
// Interface   : memory_stage_if
// Description : Data-bus request/response pair. The pipeline stage is the
//               master; the memory system is the slave.
// Revision    : 1.0 - initial release
//==============================================================================
interface memory_stage_if;
   import memory_stage_pkg::*;

   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);

endinterface
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
//==============================================================================
// Module      : mem_align
// Description : Combinational lane alignment for the M stage. Derives bus
//               size and byte strobe, shifts store data into its lanes and
//               shifts/extends returned load data down to bit 0.
// Revision    : 1.0 - initial release
//==============================================================================
module mem_align
   import memory_stage_pkg::*;
(
   input  op_t        i_op,
   input  logic [2:0] i_addrLow,
   input  word_t      i_storeData,
   input  word_t      i_respData,
   output msize_t     o_size,
   output strobe_t    o_strobe,
   output word_t      o_writeData,
   output word_t      o_loadData
);

   localparam strobe_t c_STRB_B = 8'h01;
   localparam strobe_t c_STRB_H = 8'h03;
   localparam strobe_t c_STRB_W = 8'h0F;
   localparam strobe_t c_STRB_D = 8'hFF;

   logic [5:0] w_shift;
   word_t      w_raw;

   // Byte offset within the doubleword expressed as a bit shift
   assign w_shift     = {i_addrLow, 3'b000};
   assign o_writeData = i_storeData << w_shift;
   assign w_raw       = i_respData >> w_shift;

   // Access size and strobe; loads leave the strobe clear
   always_comb begin
      o_size   = MSIZE1;
      o_strobe = '0;
      case (i_op)
         LB, LBU: o_size = MSIZE1;
         LH, LHU: o_size = MSIZE2;
         LW, LWU: o_size = MSIZE4;
         LD:      o_size = MSIZE8;
         SB: begin
            o_size   = MSIZE1;
            o_strobe = c_STRB_B << i_addrLow;
         end
         SH: begin
            o_size   = MSIZE2;
            o_strobe = c_STRB_H << i_addrLow;
         end
         SW: begin
            o_size   = MSIZE4;
            o_strobe = c_STRB_W << i_addrLow;
         end
         SD: begin
            o_size   = MSIZE8;
            o_strobe = c_STRB_D << i_addrLow;
         end
         default: ;
      endcase
   end

   // Truncate aligned load data to the access size and extend to 64 bits
   always_comb begin
      o_loadData = '0;
      case (i_op)
         LB:  o_loadData = {{56{w_raw[7]}},  w_raw[7:0]};
         LH:  o_loadData = {{48{w_raw[15]}}, w_raw[15:0]};
         LW:  o_loadData = {{32{w_raw[31]}}, w_raw[31:0]};
         LD:  o_loadData = w_raw;
         LBU: o_loadData = {56'd0, w_raw[7:0]};
         LHU: o_loadData = {48'd0, w_raw[15:0]};
         LWU: o_loadData = {32'd0, w_raw[31:0]};
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
//==============================================================================
// Module      : memory_stage
// Description : RV64 pipeline M stage. Issues loads/stores on the data bus,
//               stalls while an access is outstanding, captures the aligned
//               and extended load data and hands the result to writeback.
//               Non-memory ops and bubbles pass straight through.
// Revision    : 1.0 - initial release
//==============================================================================
module memory_stage
   import memory_stage_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  execute_data_t dataE,
   input  logic          stall_in,
   output logic          stall_out,
   memory_stage_if.master dbus,
   output memory_data_t  dataM
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t  r_state;
   word_t   r_capture;

   logic    w_isMem;
   logic    w_isStore;
   logic    w_reqValid;
   msize_t  w_size;
   strobe_t w_strobe;
   word_t   w_writeData;
   word_t   w_loadData;
   word_t   w_extData;
   logic    w_unusedAddrOk;

   // Completion is signalled by data_ok alone; addr_ok carries no meaning here
   assign w_unusedAddrOk = dbus.dresp.addr_ok;

   assign w_isMem   = !dataE.is_bubble && isMemOp(dataE.ctl.op);
   assign w_isStore = isStore(dataE.ctl.op);
   assign w_extData = w_isStore ? '0 : w_loadData;

   mem_align u_align (
      .i_op        (dataE.ctl.op),
      .i_addrLow   (dataE.memory_address[2:0]),
      .i_storeData (dataE.result),
      .i_respData  (dbus.dresp.data),
      .o_size      (w_size),
      .o_strobe    (w_strobe),
      .o_writeData (w_writeData),
      .o_loadData  (w_loadData)
   );

   // Access sequencing: issue, wait for data_ok, hold result until M/W advances
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_capture <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_isMem) begin
                  if (dbus.dresp.data_ok) begin
                     r_capture <= w_extData;
                     r_state   <= S_DONE;
                  end else begin
                     r_state   <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (dbus.dresp.data_ok) begin
                  r_capture <= w_extData;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               if (!stall_in) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Request valid and stall share one source; neither looks at the response
   always_comb begin
      w_reqValid = 1'b0;
      if (!reset) begin
         case (r_state)
            S_IDLE:  w_reqValid = w_isMem;
            S_BUSY:  w_reqValid = 1'b1;
            default: w_reqValid = 1'b0;
         endcase
      end
      stall_out = w_reqValid;
   end

   // Bus request; fields come straight from the held dataE so they stay stable
   always_comb begin
      dbus.dreq = '0;
      if (w_reqValid) begin
         dbus.dreq.valid  = 1'b1;
         dbus.dreq.addr   = dataE.memory_address;
         dbus.dreq.size   = w_size;
         dbus.dreq.strobe = w_strobe;
         dbus.dreq.data   = w_writeData;
      end
   end

   // Writeback payload; a stalled memory op is presented as a bubble
   always_comb begin
      dataM           = '0;
      dataM.is_bubble = 1'b1;
      if (!reset) begin
         dataM.pc        = dataE.pc;
         dataM.ctl       = dataE.ctl;
         dataM.dst       = dataE.dst;
         dataM.result    = (r_state == S_DONE) ? r_capture : dataE.result;
         dataM.is_bubble = dataE.is_bubble | stall_out;
      end
   end

endmodule
`default_nettype wire
